// File: rtl/receiver_pkg.sv
// rtl/receiver_pkg.sv - shared constants, state encoding and CRC-32 byte step for the GMII receiver
package receiver_pkg;

    localparam int HDR_LEN   = 0;
    localparam int HDR_TS0   = 1;
    localparam int HDR_TS1   = 2;
    localparam int HDR_TS2   = 3;
    localparam int HDR_TS3   = 4;
    localparam int HDR_FCS0  = 5;
    localparam int HDR_FCS1  = 6;
    localparam int HDR_WORDS = 7;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_HDR_WR,
        ST_DROP
    } rx_state_t;

    // MSB-first register, bits fed LSB-first as they arrive on the wire.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/receiver_if.sv
// rtl/receiver_if.sv - RX slot ring write bus
interface receiver_if;
    logic [15:0] slot_rx_eth_data;
    logic [1:0]  slot_rx_eth_byte_en;
    logic [13:0] slot_rx_eth_addr;
    logic        slot_rx_eth_wr_en;

    modport master (
        output slot_rx_eth_data,
        output slot_rx_eth_byte_en,
        output slot_rx_eth_addr,
        output slot_rx_eth_wr_en
    );

    modport slave (
        input slot_rx_eth_data,
        input slot_rx_eth_byte_en,
        input slot_rx_eth_addr,
        input slot_rx_eth_wr_en
    );
endinterface

// File: rtl/receiver_rx_crc32.sv
// rtl/receiver_rx_crc32.sv - byte-wide Ethernet CRC-32 register with residue compare
module rx_crc32
    import receiver_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       data_en,
    input  logic [7:0] data,
    output logic       residue_ok
);
    logic [31:0] crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '1;
        end else if (init) begin
            crc_q <= '1;
        end else if (data_en) begin
            crc_q <= crc32_byte(crc_q, data);
        end
    end

    assign residue_ok = (crc_q == CRC_RESIDUE);
endmodule

// File: rtl/receiver.sv
// rtl/receiver.sv - GMII frame receiver into the RX slot ring; option macro RX_FCS_DROP_EN
module receiver
    import receiver_pkg::*;
#(
    parameter int MAX_FRAME = 1522,
    parameter int MIN_FRAME = 64
) (
    input  logic        gmii_rx_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] global_counter,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    receiver_if.master  slot,
    output logic [13:0] mem_wr_ptr,
    input  logic [13:0] mem_rd_ptr,
    output logic [31:0] rx_frame_count,
    output logic [15:0] rx_drop_count
);
    localparam logic [15:0] MIN_CNT = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_CNT = 16'(MAX_FRAME);

    logic [7:0]  rxd_q;
    logic        dv_q, er_q, dv_prev;
    rx_state_t   state, next_state;

    logic [63:0] ts_q;
    logic [13:0] wp;
    logic [15:0] byte_cnt;
    logic [7:0]  hold_byte;
    logic [31:0] fcs_sr;
    logic        er_seen;
    logic [2:0]  hdr_idx;
    logic        publish;

    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [13:0] wr_addr;
    logic        wr_en;

    logic        dv_rise, hdr_room, wp_full, frame_bad, crc_ok;
    logic        fcs_drop, fcs_flag;
    logic [13:0] hdr_gap;
    logic [15:0] hdr_word;
    logic        sfd_hit, byte_take, tail_wr, hdr_wr, hdr_last, drop_enter;

    rx_crc32 u_crc (
        .clk        (gmii_rx_clk),
        .rst_n      (sys_rst_n),
        .init       (sfd_hit),
        .data_en    (byte_take),
        .data       (rxd_q),
        .residue_ok (crc_ok)
    );

`ifdef RX_FCS_DROP_EN
    assign fcs_drop = ~crc_ok;
    assign fcs_flag = 1'b0;
`else
    assign fcs_drop = 1'b0;
    assign fcs_flag = ~crc_ok;
`endif

    assign dv_rise   = dv_q & ~dv_prev;
    // Header words land at mem_wr_ptr..+6; none of them may step onto the reader.
    assign hdr_gap   = mem_rd_ptr - mem_wr_ptr - 14'd1;
    assign hdr_room  = (hdr_gap >= 14'(HDR_WORDS));
    assign wp_full   = ((wp + 14'd1) == mem_rd_ptr);
    assign frame_bad = er_seen | (byte_cnt < MIN_CNT) | (byte_cnt > MAX_CNT) | fcs_drop;

    always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        sfd_hit    = 1'b0;
        byte_take  = 1'b0;
        tail_wr    = 1'b0;
        hdr_wr     = 1'b0;
        hdr_last   = 1'b0;
        drop_enter = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dv_rise) begin
                    next_state = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (!dv_q) begin
                    next_state = ST_DROP;
                    drop_enter = 1'b1;
                end else if (rxd_q == SFD_BYTE) begin
                    if (hdr_room) begin
                        next_state = ST_DATA;
                        sfd_hit    = 1'b1;
                    end else begin
                        next_state = ST_DROP;
                        drop_enter = 1'b1;
                    end
                end else if (rxd_q != PREAMBLE_BYTE) begin
                    next_state = ST_DROP;
                    drop_enter = 1'b1;
                end
            end
            ST_DATA: begin
                if (dv_q) begin
                    if ((byte_cnt == MAX_CNT) || (byte_cnt[0] && wp_full)) begin
                        next_state = ST_DROP;
                        drop_enter = 1'b1;
                    end else begin
                        byte_take = 1'b1;
                    end
                end else if (frame_bad || (byte_cnt[0] && wp_full)) begin
                    next_state = ST_DROP;
                    drop_enter = 1'b1;
                end else begin
                    tail_wr    = byte_cnt[0];
                    next_state = ST_HDR_WR;
                end
            end
            ST_HDR_WR: begin
                hdr_wr = 1'b1;
                if (hdr_idx == 3'(HDR_FCS1)) begin
                    hdr_last = 1'b1;
                    // A frame that started during the header missed its preamble.
                    if (dv_q) begin
                        next_state = ST_DROP;
                        drop_enter = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (!dv_q) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        hdr_word = 16'h0000;
        case (hdr_idx)
            3'(HDR_LEN):  hdr_word = (byte_cnt - 16'd4) | {fcs_flag, 15'h0000};
            3'(HDR_TS0):  hdr_word = ts_q[63:48];
            3'(HDR_TS1):  hdr_word = ts_q[47:32];
            3'(HDR_TS2):  hdr_word = ts_q[31:16];
            3'(HDR_TS3):  hdr_word = ts_q[15:0];
            3'(HDR_FCS0): hdr_word = fcs_sr[31:16];
            3'(HDR_FCS1): hdr_word = fcs_sr[15:0];
            default:      hdr_word = 16'h0000;
        endcase
    end

    always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_q          <= '0;
            dv_q           <= 1'b0;
            er_q           <= 1'b0;
            dv_prev        <= 1'b0;
            ts_q           <= '0;
            wp             <= '0;
            byte_cnt       <= '0;
            hold_byte      <= '0;
            fcs_sr         <= '0;
            er_seen        <= 1'b0;
            hdr_idx        <= '0;
            publish        <= 1'b0;
            wr_data        <= '0;
            wr_be          <= '0;
            wr_addr        <= '0;
            wr_en          <= 1'b0;
            mem_wr_ptr     <= '0;
            rx_frame_count <= '0;
            rx_drop_count  <= '0;
        end else begin
            rxd_q   <= gmii_rxd;
            dv_q    <= gmii_rx_dv;
            er_q    <= gmii_rx_er;
            dv_prev <= dv_q;
            wr_en   <= 1'b0;
            wr_be   <= 2'b00;
            publish <= hdr_last;

            if (publish) begin
                mem_wr_ptr     <= wp;
                rx_frame_count <= rx_frame_count + 32'd1;
            end
            if (drop_enter && (rx_drop_count != 16'hFFFF)) begin
                rx_drop_count <= rx_drop_count + 16'd1;
            end

            if (sfd_hit) begin
                ts_q     <= global_counter;
                wp       <= mem_wr_ptr + 14'(HDR_WORDS);
                byte_cnt <= '0;
                er_seen  <= 1'b0;
                hdr_idx  <= '0;
            end

            if (byte_take) begin
                byte_cnt <= byte_cnt + 16'd1;
                er_seen  <= er_seen | er_q;
                fcs_sr   <= {fcs_sr[23:0], rxd_q};
                if (byte_cnt[0]) begin
                    wr_en   <= 1'b1;
                    wr_be   <= 2'b11;
                    wr_addr <= wp;
                    wr_data <= {hold_byte, rxd_q};
                    wp      <= wp + 14'd1;
                end else begin
                    hold_byte <= rxd_q;
                end
            end

            if (tail_wr) begin
                wr_en   <= 1'b1;
                wr_be   <= 2'b10;
                wr_addr <= wp;
                wr_data <= {hold_byte, 8'h00};
                wp      <= wp + 14'd1;
            end

            if (hdr_wr) begin
                wr_en   <= 1'b1;
                wr_be   <= 2'b11;
                wr_addr <= mem_wr_ptr + {11'd0, hdr_idx};
                wr_data <= hdr_word;
                hdr_idx <= hdr_idx + 3'd1;
            end
        end
    end

    assign slot.slot_rx_eth_data    = wr_data;
    assign slot.slot_rx_eth_byte_en = wr_be;
    assign slot.slot_rx_eth_addr    = wr_addr;
    assign slot.slot_rx_eth_wr_en   = wr_en;
endmodule

// File: doc/receiver.md
# receiver

GMII frame receiver: strips preamble/SFD from `gmii_rxd`, checks Ethernet FCS, and writes each frame into the RX frame slot ring as a 7-word header plus 16-bit data words. It is the receive-side counterpart of the TX slot sender and uses the same slot header layout: length, 64-bit timestamp, 32-bit word. It advances `mem_wr_ptr` only after a complete, accepted frame, so the host reader never sees partial slots.

## Interface
Parameters:
- `MAX_FRAME`, 1522: maximum accepted frame bytes, including FCS.
- `MIN_FRAME`, 64: minimum accepted frame bytes, including FCS.

Ports:
- `gmii_rx_clk`  in  1  sole clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `global_counter`  in  64  free-running time; sampled at SFD.
- `gmii_rxd`  in  8  GMII receive data.
- `gmii_rx_dv`  in  1  GMII data valid.
- `gmii_rx_er`  in  1  GMII receive error.
- `slot_rx_eth_data`  out  16  write data; first byte in [15:8].
- `slot_rx_eth_byte_en`  out  2  byte enables; [1] enables [15:8].
- `slot_rx_eth_addr`  out  14  write word address.
- `slot_rx_eth_wr_en`  out  1  write strobe.
- `mem_wr_ptr`  out  14  published ring write pointer (word address).
- `mem_rd_ptr`  in  14  host reader pointer.
- `rx_frame_count`  out  32  accepted frames.
- `rx_drop_count`  out  16  dropped frames (any cause).

## Operation
- GMII inputs are registered once before use.
- States: IDLE, PREAMBLE, DATA, HDR_WR, DROP.
- IDLE: `rx_dv` rising edge -> PREAMBLE.
- PREAMBLE:
  - byte 0x55 stays in PREAMBLE.
  - byte 0xD5 -> DATA; latch `global_counter` as the timestamp; set `wp = mem_wr_ptr + 7`; clear the byte count; initialise the CRC.
  - any other byte, or `rx_dv` low -> DROP.
- DATA:
  - Even byte: holds to [15:8].
  - Odd byte: writes the word at `wp` with `byte_en` = 2'b11; then `wp <= wp + 1`.
  - All bytes, including the FCS, are fed to the CRC and stored in the slot.
- DATA end, on `rx_dv` falling:
  - If the byte count is odd, write the final word with `byte_en` = 2'b10 and [7:0] = 0.
  - Error conditions: `rx_er` seen; byte count outside [`MIN_FRAME`, `MAX_FRAME`]; bad FCS (CRC residue ≠ 32'hC704DD7B).
- Overflow: the ring is full when `wp + 1 == mem_rd_ptr` (mod 2^14). Any write that would reach `mem_rd_ptr` -> DROP immediately. This includes header words, so the check covers `mem_wr_ptr .. wp`.
- Byte count reaching `MAX_FRAME + 1` while `rx_dv` is high -> DROP.
- HDR_WR: write 7 words at `mem_wr_ptr + 0..6`:
  - word 0: frame length excluding FCS (byte count − 4).
  - words 1..4: timestamp [63:48], [47:32], [31:16], [15:0].
  - words 5..6: received FCS [31:16], [15:0].
  - After word 6: `mem_wr_ptr <= wp`, `rx_frame_count++`, state -> IDLE.
- DROP: no writes; `mem_wr_ptr` unchanged; `rx_drop_count++` (saturating) on entry; wait for `rx_dv` low, then IDLE.
- Pointer arithmetic is modulo 2^14. Addresses wrap from 14'h3FFF to 0 with no special handling.

## Timing
- Reset values: all outputs and counters 0; `wr_en`/`byte_en` 0; state IDLE.
- Reset mid-frame discards the partial frame; `mem_wr_ptr` returns to 0.
- Data write: `wr_en` is asserted 2 cycles after the odd byte appears on the pins.
- End of frame: the tail word is written on the cycle after `rx_dv` low is registered. HDR_WR occupies the next 7 consecutive cycles.
- Publish: `mem_wr_ptr` updates on the cycle after the word-6 write. The end-to-publish latency is at most 10 cycles, which is shorter than IFG + preamble (20 cycles).
- `rx_dv` rising during HDR_WR (IFG violation): finish the header, then treat the new frame as DROP (counted).
- At most one write per cycle; `wr_en` is a single-cycle strobe.

## Configuration
- `RX_FCS_DROP_EN` defined: FCS-error frames are dropped (counted; `mem_wr_ptr` not advanced).
- `RX_FCS_DROP_EN` undefined:
  - FCS-error frames are stored and published, with header word 0 bit 15 set to 1 as an error flag.
  - `rx_er`, runt/oversize and overflow frames are still dropped.
  - `rx_frame_count` counts these frames.

## Structure
- Shared package holds:
  - header word offsets: `HDR_LEN`=0, `HDR_TS0..3`=1..4, `HDR_FCS0..1`=5..6, `HDR_WORDS`=7.
  - preamble and SFD constants: 8'h55, 8'hD5.
  - CRC residue: 32'hC704DD7B.
  - state encoding.
- Sub-module `rx_crc32`: byte-wide CRC-32 register with `init`/`data_en` and residue-compare output.

## Test plan
- Valid 64-byte frame (60 data + correct FCS), `mem_wr_ptr`=0 -> 32 data words at addr 7..38; header `len`=60, timestamp = `global_counter` at SFD; `mem_wr_ptr`=39; `rx_frame_count`=1.
- 65-byte frame -> last data word has `byte_en`=2'b10; `len`=61; `mem_wr_ptr` advances by 7 + 33 = 40.
- Corrupted FCS byte:
  - with `RX_FCS_DROP_EN` -> `mem_wr_ptr` unchanged, `rx_drop_count`=1.
  - without it -> published with header word 0 = 16'h8000 | `len`.
- `mem_rd_ptr` = `mem_wr_ptr` + 20, 64-byte frame -> DROP; no write at or beyond `mem_rd_ptr`; `rx_drop_count`=1.
- `mem_wr_ptr`=14'h3FF0, 100-byte frame -> addresses wrap through 0; `mem_wr_ptr` = (3FF0 + 57) mod 2^14 = 14'h0029.
- `rx_er` pulse mid-frame, bad SFD (0x5D), or 1600-byte frame -> dropped; the next valid frame is accepted normally; `sys_rst_n` low mid-frame -> all outputs 0.
